// File: rtl/lcd_pixel_sink.sv
// Packs the PPU's 2-bit pixel stream into bytes and writes them to the LCD framebuffer through a small write FIFO.
// Optional feature: define DOUBLE_BUFFER_EN for ping-pong framebuffer banks (FB_ADDR[13] / DISP_BANK).
module lcd_pixel_sink #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PX_OUT,
    input  logic        PX_valid,
    input  logic [1:0]  PPU_MODE,
    output logic        FB_WR,
    output logic [13:0] FB_ADDR,
    output logic [7:0]  FB_DATA,
    input  logic        FB_ACK,
    output logic        FRAME_DONE,
    output logic        DISP_BANK,
    output logic        OVERRUN,
    output logic        LINE_ERR
);
    localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int XW  = $clog2(WIDTH + 1);
    localparam int YW  = $clog2(HEIGHT + 1);
    localparam int BPL = WIDTH / 4;
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_END     = YW'(HEIGHT);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_EMPTY = (AW+1)'(0);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_HBLANK = 2'd2;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [5:0]    pack_q, pack_d;
    logic [1:0]    mode_q;
    logic [1:0]    state_q, state_d;
    logic          line_err_q, line_err_d;
    logic          overrun_q;
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q, count_d;
    logic [12:0]   mem_addr_q [FIFO_DEPTH];
    logic [7:0]    mem_data_q [FIFO_DEPTH];

    logic          vb_edge_s, hb_edge_s;
    logic          push_s, pop_s, full_s, accept_s, drop_s;
    logic [12:0]   push_addr_s;
    logic [7:0]    push_data_s;
    logic          head_bank_s;

    assign vb_edge_s = (PPU_MODE == MODE_VBLANK) && (mode_q != MODE_VBLANK);
    assign hb_edge_s = (PPU_MODE == MODE_HBLANK) && (mode_q != MODE_HBLANK);

    // Position tracking and packing; mode edges are applied before the pixel of the same cycle.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        pack_d      = pack_q;
        line_err_d  = line_err_q;
        push_s      = 1'b0;
        push_addr_s = 13'h0000;
        push_data_s = 8'h00;
        if (vb_edge_s) begin
            if (y_q != Y_END) begin
                line_err_d = 1'b1;
            end else begin
                line_err_d = line_err_q;
            end
            x_d    = '0;
            y_d    = '0;
            pack_d = 6'h00;
        end else if (hb_edge_s && (x_q != '0)) begin
            line_err_d = 1'b1;
            x_d        = '0;
            pack_d     = 6'h00;
            if (y_q != Y_END) begin
                y_d = y_q + 1'b1;
            end else begin
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
        end
        if (PX_valid) begin
            if (y_d == Y_END) begin
                line_err_d = 1'b1;
            end else begin
                case (x_d[1:0])
                    2'd0:    pack_d[5:4] = PX_OUT;
                    2'd1:    pack_d[3:2] = PX_OUT;
                    2'd2:    pack_d[1:0] = PX_OUT;
                    default: begin
                        push_s      = 1'b1;
                        push_data_s = {pack_d, PX_OUT};
                    end
                endcase
                push_addr_s = 13'(int'(y_d) * BPL + int'(x_d[XW-1:2]));
                if (x_d == X_LAST) begin
                    x_d = '0;
                    y_d = y_d + 1'b1;
                end else begin
                    x_d = x_d + 1'b1;
                end
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign full_s   = (count_q == CNT_FULL);
    assign pop_s    = (count_q != CNT_EMPTY) && FB_ACK;
    assign accept_s = push_s && (!full_s || pop_s);
    assign drop_s   = push_s && full_s && !pop_s;
    assign count_d  = count_q + (AW+1)'(accept_s) - (AW+1)'(pop_s);

    // Frame sequencing: wait for the buffer to drain before announcing the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (vb_edge_s) state_d = ST_FLUSH;
                else           state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if ((count_q == CNT_EMPTY) && !push_s) state_d = ST_DONE;
                else                                   state_d = ST_FLUSH;
            end
            ST_DONE: begin
                if (vb_edge_s) state_d = ST_FLUSH;
                else           state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            pack_q     <= 6'h00;
            mode_q     <= 2'd0;
            state_q    <= ST_RUN;
            line_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_EMPTY;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            pack_q     <= pack_d;
            mode_q     <= PPU_MODE;
            state_q    <= state_d;
            line_err_q <= line_err_d;
            overrun_q  <= overrun_q | drop_s;
            count_q    <= count_d;
            if (accept_s) tail_q <= tail_q + 1'b1;
            if (pop_s)    head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_addr_q[tail_q] <= push_addr_s;
            mem_data_q[tail_q] <= push_data_s;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic wbank_q, disp_q, push_bank_s;
    logic mem_bank_q [FIFO_DEPTH];

    // Bytes pushed after V_BLANK entry already belong to the next frame's bank.
    assign push_bank_s = (state_q == ST_RUN) ? wbank_q : ~wbank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q <= 1'b0;
            disp_q  <= 1'b0;
        end else if (state_q == ST_DONE) begin
            wbank_q <= ~wbank_q;
            disp_q  <= wbank_q;
        end else begin
            wbank_q <= wbank_q;
            disp_q  <= disp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_s) mem_bank_q[tail_q] <= push_bank_s;
    end

    assign head_bank_s = mem_bank_q[head_q];
    assign DISP_BANK   = disp_q;
`else
    assign head_bank_s = 1'b0;
    assign DISP_BANK   = 1'b0;
`endif

    assign FB_WR      = (count_q != CNT_EMPTY);
    assign FB_ADDR    = FB_WR ? {head_bank_s, mem_addr_q[head_q]} : 14'h0000;
    assign FB_DATA    = FB_WR ? mem_data_q[head_q] : 8'h00;
    assign FRAME_DONE = (state_q == ST_DONE);
    assign OVERRUN    = overrun_q;
    assign LINE_ERR   = line_err_q;
endmodule

// File: tb/tb_lcd_pixel_sink.sv
// Randomized bench for lcd_pixel_sink against a queue-based reference model of the pixel stream.
module tb_lcd_pixel_sink;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  PX_OUT = 2'd0;
    logic        PX_valid = 1'b0;
    logic [1:0]  PPU_MODE = 2'd3;
    logic        FB_ACK = 1'b0;
    logic        FB_WR, FRAME_DONE, DISP_BANK, OVERRUN, LINE_ERR;
    logic [13:0] FB_ADDR;
    logic [7:0]  FB_DATA;

    int vectors = 0;
    int miscompares = 0;

`ifdef DOUBLE_BUFFER_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif

    lcd_pixel_sink dut (
        .clk(clk), .rst(rst), .PX_OUT(PX_OUT), .PX_valid(PX_valid), .PPU_MODE(PPU_MODE),
        .FB_WR(FB_WR), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_ACK(FB_ACK),
        .FRAME_DONE(FRAME_DONE), .DISP_BANK(DISP_BANK), .OVERRUN(OVERRUN), .LINE_ERR(LINE_ERR)
    );

    always #5 clk = ~clk;

    // Reference model: beam position, pixel slots and a bounded queue of {addr,byte}.
    int mx, my, mprev;
    int slot[4];
    int mq[$];
    bit m_lerr, m_ovr;

    task automatic model_cycle(input bit v, input int p, input int m, input bit a);
        bit pop, push;
        int sz, byte_v, addr_v;
        sz = mq.size();
        pop = (sz > 0) && a;
        push = 1'b0;
        byte_v = 0;
        addr_v = 0;
        if (m == 1 && mprev != 1) begin
            if (my != 144) m_lerr = 1'b1;
            mx = 0; my = 0;
        end else if (m == 2 && mprev != 2 && mx != 0) begin
            m_lerr = 1'b1;
            mx = 0;
            if (my != 144) my++;
        end
        if (v) begin
            if (my == 144) m_lerr = 1'b1;
            else begin
                slot[mx % 4] = p;
                if (mx % 4 == 3) begin
                    push = 1'b1;
                    byte_v = slot[0] * 64 + slot[1] * 16 + slot[2] * 4 + slot[3];
                    addr_v = my * 40 + mx / 4;
                end
                mx++;
                if (mx == 160) begin mx = 0; my++; end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (sz == 8 && !pop) m_ovr = 1'b1;
            else mq.push_back(addr_v * 256 + byte_v);
        end
        mprev = m;
    endtask

    task automatic step(input bit v, input int p, input int m, input bit a);
        PX_valid = v; PX_OUT = 2'(p); PPU_MODE = 2'(m); FB_ACK = a;
        model_cycle(v, p, m, a);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; PX_valid = 1'b0; PPU_MODE = 2'd3; FB_ACK = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        mx = 0; my = 0; mprev = 0; mq.delete(); m_lerr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({FB_WR, FRAME_DONE, DISP_BANK, OVERRUN, LINE_ERR} !== 5'b0 || FB_ADDR !== 14'h0 || FB_DATA !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got wr=%b fd=%b db=%b ov=%b le=%b a=%h d=%h want all 0",
                     FB_WR, FRAME_DONE, DISP_BANK, OVERRUN, LINE_ERR, FB_ADDR, FB_DATA);
        end
    endtask

    task automatic test_single_group();
        do_reset();
        step(1, 3, 3, 1); step(1, 2, 3, 1); step(1, 1, 3, 1);
        vectors++;
        if (FB_WR !== 1'b0) begin miscompares++; $display("FAIL single_early got wr=%b want 0", FB_WR); end
        step(1, 0, 3, 1);
        vectors++;
        if (FB_WR !== 1'b1 || FB_ADDR !== 14'h0000 || FB_DATA !== 8'hE4) begin
            miscompares++;
            $display("FAIL single_group got wr=%b a=%h d=%h want 1 0000 e4", FB_WR, FB_ADDR, FB_DATA);
        end
        step(0, 0, 3, 1);
        vectors++;
        if (FB_WR !== 1'b0) begin miscompares++; $display("FAIL single_pop got wr=%b want 0", FB_WR); end
    endtask

    task automatic test_random_stream();
        bit a;
        logic [13:0] ea;
        logic [7:0] ed;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            vectors++;
            if (FB_WR !== (mq.size() > 0) || OVERRUN !== m_ovr || LINE_ERR !== m_lerr) begin
                miscompares++;
                $display("FAIL rand_flags c=%0d got wr=%b ov=%b le=%b want %b %b %b",
                         c, FB_WR, OVERRUN, LINE_ERR, mq.size() > 0, m_ovr, m_lerr);
            end
            if (mq.size() > 0) begin
                ea = 14'(mq[0] / 256);
                ed = 8'(mq[0] % 256);
                vectors++;
                if (FB_ADDR !== ea || FB_DATA !== ed) begin
                    miscompares++;
                    $display("FAIL rand_head c=%0d got a=%h d=%h want a=%h d=%h", c, FB_ADDR, FB_DATA, ea, ed);
                end
            end
            a = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), 3, a);
        end
    endtask

    task automatic test_frame(input int exp_bank, input int exp_disp);
        int writes, pulses, m;
        bit v;
        logic [13:0] ea;
        logic [7:0] ed;
        writes = 0; pulses = 0;
        for (int c = 0; c < 23040 + 40; c++) begin
            if (FB_WR === 1'b1) begin
                ea = {1'(exp_bank), 13'(writes)};
                ed = (mq.size() > 0) ? 8'(mq[0] % 256) : 8'h00;
                vectors++;
                if (FB_ADDR !== ea || FB_DATA !== ed) begin
                    miscompares++;
                    $display("FAIL frame_write n=%0d got a=%h d=%h want a=%h d=%h", writes, FB_ADDR, FB_DATA, ea, ed);
                end
                writes++;
            end
            if (FRAME_DONE === 1'b1) begin
                pulses++;
                vectors++;
                if (writes != 5760 || FB_WR !== 1'b0) begin
                    miscompares++;
                    $display("FAIL frame_done_early got writes=%0d wr=%b want 5760 0", writes, FB_WR);
                end
            end
            v = (c < 23040);
            m = (c < 23040) ? 3 : 1;
            step(v, $urandom_range(0, 3), m, 1);
        end
        vectors++;
        if (writes != 5760 || pulses != 1 || LINE_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_totals got writes=%0d pulses=%0d le=%b want 5760 1 0", writes, pulses, LINE_ERR);
        end
        vectors++;
        if (DISP_BANK !== 1'(exp_disp)) begin
            miscompares++;
            $display("FAIL frame_disp_bank got %b want %0d", DISP_BANK, exp_disp);
        end
        step(0, 0, 3, 1);
    endtask

    task automatic test_backpressure();
        int drained;
        logic [7:0] ed;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (mq.size() > 0) begin
                vectors++;
                if (FB_WR !== 1'b1 || FB_ADDR !== 14'h0000 || FB_DATA !== 8'(mq[0] % 256)) begin
                    miscompares++;
                    $display("FAIL bp_stable c=%0d got wr=%b a=%h d=%h want 1 0000 %h", c, FB_WR, FB_ADDR, FB_DATA, 8'(mq[0] % 256));
                end
            end
            step(1, $urandom_range(0, 3), 3, 0);
        end
        vectors++;
        if (FB_WR !== 1'b1 || OVERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_overrun got wr=%b ov=%b want 1 1", FB_WR, OVERRUN);
        end
        drained = 0;
        for (int c = 0; c < 12; c++) begin
            if (FB_WR === 1'b1) begin
                ed = (mq.size() > 0) ? 8'(mq[0] % 256) : 8'h00;
                vectors++;
                if (FB_ADDR !== 14'(drained) || FB_DATA !== ed) begin
                    miscompares++;
                    $display("FAIL bp_drain n=%0d got a=%h d=%h want a=%h d=%h", drained, FB_ADDR, FB_DATA, 14'(drained), ed);
                end
                drained++;
            end
            step(0, 0, 3, 1);
        end
        vectors++;
        if (drained != 8 || OVERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_count got drained=%0d ov=%b want 8 1", drained, OVERRUN);
        end
    endtask

    task automatic test_short_line();
        do_reset();
        for (int c = 0; c < 5 * 160 + 100; c++) step(1, $urandom_range(0, 3), 3, 1);
        vectors++;
        if (LINE_ERR !== 1'b0) begin miscompares++; $display("FAIL short_pre got le=%b want 0", LINE_ERR); end
        step(0, 0, 2, 1);
        vectors++;
        if (LINE_ERR !== 1'b1) begin miscompares++; $display("FAIL short_err got le=%b want 1", LINE_ERR); end
        for (int c = 0; c < 4; c++) step(1, $urandom_range(0, 3), 3, 1);
        vectors++;
        if (FB_WR !== 1'b1 || FB_ADDR !== 14'd240 || mq.size() != 1 || FB_DATA !== 8'(mq[0] % 256)) begin
            miscompares++;
            $display("FAIL short_next got wr=%b a=%0d d=%h want 1 240", FB_WR, FB_ADDR, FB_DATA);
        end
    endtask

    task automatic test_reset_mid();
        int p[4];
        do_reset();
        for (int c = 0; c < 20; c++) step(1, $urandom_range(0, 3), 3, 0);
        vectors++;
        if (FB_WR !== 1'b1) begin miscompares++; $display("FAIL mid_queued got wr=%b want 1", FB_WR); end
        do_reset();
        vectors++;
        if (FB_WR !== 1'b0 || FRAME_DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got wr=%b fd=%b want 0 0", FB_WR, FRAME_DONE);
        end
        for (int c = 0; c < 4; c++) begin
            p[c] = $urandom_range(0, 3);
            step(1, p[c], 3, 0);
        end
        vectors++;
        if (FB_WR !== 1'b1 || FB_ADDR !== 14'h0000 || FB_DATA !== 8'(p[0] * 64 + p[1] * 16 + p[2] * 4 + p[3])) begin
            miscompares++;
            $display("FAIL mid_next got wr=%b a=%h d=%h want 1 0000 %h", FB_WR, FB_ADDR, FB_DATA,
                     8'(p[0] * 64 + p[1] * 16 + p[2] * 4 + p[3]));
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_random_stream();
        test_backpressure();
        test_short_line();
        test_reset_mid();
        do_reset();
        test_frame(0, 0);
        test_frame(DB, DB);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
